param_shift_pipe: RTL and testbench



---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_stage.sv | 75 +++++++
 rtl/param_shift_pipe.sv | 92 +++++++++
 tb/tb_param_shift_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - operation encodings and helpers for the pipelined shift/rotate unit
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // Encodings 5..7 are reserved: the operand passes through and is flagged.
    function automatic logic is_reserved_op(input logic [2:0] op);
        return op > 3'd4;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one registered log-stage: shift/rotate by 2^STAGE_IDX when its shamt bit is set
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 4,
    parameter int SHAMT_W   = 5,
    parameter int STAGE_IDX = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_tvalid,
    output logic               src_tready,
    input  logic [WIDTH-1:0]   src_tdata,
    input  logic [2:0]         src_op,
    input  logic [SHAMT_W-1:0] src_shamt,
    input  logic               src_sign,
    input  logic [TAG_W-1:0]   src_tag,
    input  logic               src_err,
    output logic               dst_tvalid,
    input  logic               dst_tready,
    output logic [WIDTH-1:0]   dst_tdata,
    output logic [2:0]         dst_op,
    output logic [SHAMT_W-1:0] dst_shamt,
    output logic               dst_sign,
    output logic [TAG_W-1:0]   dst_tag,
    output logic               dst_err
);

    localparam int STEP = 1 << STAGE_IDX;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fill;

    always_comb begin
        shifted = src_tdata;
        // Bits vacated at the top by SRA take the sign captured at pipeline entry.
        fill    = src_sign ? ~({WIDTH{1'b1}} >> STEP) : '0;
        if (src_shamt[STAGE_IDX] && !src_err) begin
            case (src_op)
                OP_SLL:  shifted = src_tdata << STEP;
                OP_SRL:  shifted = src_tdata >> STEP;
                OP_SRA:  shifted = (src_tdata >> STEP) | fill;
                OP_ROL:  shifted = (src_tdata << STEP) | (src_tdata >> (WIDTH - STEP));
                OP_ROR:  shifted = (src_tdata >> STEP) | (src_tdata << (WIDTH - STEP));
                default: shifted = src_tdata;
            endcase
        end
    end

    assign src_tready = !dst_tvalid || dst_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_tvalid <= 1'b0;
            dst_tdata  <= '0;
            dst_op     <= '0;
            dst_shamt  <= '0;
            dst_sign   <= 1'b0;
            dst_tag    <= '0;
            dst_err    <= 1'b0;
        end else if (src_tready) begin
            dst_tvalid <= src_tvalid;
            if (src_tvalid) begin
                dst_tdata <= shifted;
                dst_op    <= src_op;
                dst_shamt <= src_shamt;
                dst_sign  <= src_sign;
                dst_tag   <= src_tag;
                dst_err   <= src_err;
            end
        end
    end

endmodule

// File: rtl/param_shift_pipe.sv
// rtl/param_shift_pipe.sv - pipelined WIDTH-bit shift/rotate unit with valid/ready backpressure
module param_shift_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_err
);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("param_shift_pipe: WIDTH must be a power of two >= 2");
    end

    // Index k is the input of stage k; index SHAMT_W is the final result.
    logic               vld   [SHAMT_W+1];
    logic [WIDTH-1:0]   dat   [SHAMT_W+1];
    logic [2:0]         op    [SHAMT_W+1];
    logic [SHAMT_W-1:0] shamt [SHAMT_W+1];
    logic               sgn   [SHAMT_W+1];
    logic [TAG_W-1:0]   tag   [SHAMT_W+1];
    logic               err   [SHAMT_W+1];

    assign vld[0]   = in_valid;
    assign dat[0]   = in_data;
    assign op[0]    = in_op;
    assign shamt[0] = in_shamt;
    assign sgn[0]   = in_data[WIDTH-1];
    assign tag[0]   = in_tag;
    assign err[0]   = is_reserved_op(in_op);

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic rdy;
        logic rdy_dn;

        // Ready chain is kept per block so each link is its own net.
        if (k == SHAMT_W - 1) begin : g_tail
            assign rdy_dn = out_ready;
        end else begin : g_link
            assign rdy_dn = g_stage[k+1].rdy;
        end

        shift_stage #(
            .WIDTH     (WIDTH),
            .TAG_W     (TAG_W),
            .SHAMT_W   (SHAMT_W),
            .STAGE_IDX (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .src_tvalid (vld[k]),
            .src_tready (rdy),
            .src_tdata  (dat[k]),
            .src_op     (op[k]),
            .src_shamt  (shamt[k]),
            .src_sign   (sgn[k]),
            .src_tag    (tag[k]),
            .src_err    (err[k]),
            .dst_tvalid (vld[k+1]),
            .dst_tready (rdy_dn),
            .dst_tdata  (dat[k+1]),
            .dst_op     (op[k+1]),
            .dst_shamt  (shamt[k+1]),
            .dst_sign   (sgn[k+1]),
            .dst_tag    (tag[k+1]),
            .dst_err    (err[k+1])
        );
    end

    assign in_ready  = g_stage[0].rdy;
    assign out_valid = vld[SHAMT_W];
    assign out_data  = dat[SHAMT_W];
    assign out_tag   = tag[SHAMT_W];
    assign out_err   = err[SHAMT_W];

    logic unused_tail;
    assign unused_tail = ^{op[SHAMT_W], shamt[SHAMT_W], sgn[SHAMT_W]};

endmodule

// File: tb/tb_param_shift_pipe.sv
// tb/tb_param_shift_pipe.sv - self-checking bench for param_shift_pipe
module tb_param_shift_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_err;

    param_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference result computed from the whole shift amount at once.
    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] d, input int s);
        logic [2*W-1:0]  w;
        logic signed [W-1:0] sd;
        sd = d;
        case (op)
            3'd0: return {1'b0, d << s};
            3'd1: return {1'b0, d >> s};
            3'd2: return {1'b0, W'(sd >>> s)};
            3'd3: begin w = {d, d} << s; return {1'b0, w[2*W-1:W]}; end
            3'd4: begin w = {d, d} >> s; return {1'b0, w[W-1:0]}; end
            default: return {1'b1, d};
        endcase
    endfunction

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
        bit            lat;
    } item_t;

    item_t         q[$];
    bit            lat_mode = 0;
    int            n_pop    = 0;
    int            acc_cnt  = 0;
    logic [W-1:0]  last_data;
    logic          last_err;
    bit            prev_rst   = 0;
    bit            prev_stall = 0;
    logic [W-1:0]  prev_data;
    logic [TW-1:0] prev_tag;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_rst   = 1;
            prev_stall = 0;
        end else begin
            item_t it;
            logic [W:0] m;
            if (prev_rst) begin
                chk("reset_out_valid", out_valid, 0);
                chk("reset_out_data", out_data, 0);
                chk("reset_out_tag", out_tag, 0);
                chk("reset_out_err", out_err, 0);
            end
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", out_data, prev_data);
                chk("stall_tag_held", out_tag, prev_tag);
            end
            if (out_valid) begin
                chk("output_has_pending_op", q.size() > 0, 1);
                if (out_ready && q.size() > 0) begin
                    it = q.pop_front();
                    chk("out_data", out_data, it.data);
                    chk("out_tag", out_tag, it.tag);
                    chk("out_err", out_err, it.err);
                    if (it.lat) chk("latency", cyc - it.acc, SW);
                    last_data = out_data;
                    last_err  = out_err;
                    n_pop++;
                end
            end
            if (in_valid && in_ready) begin
                m       = model(in_op, in_data, int'(in_shamt));
                it.data = m[W-1:0];
                it.err  = m[W];
                it.tag  = in_tag;
                it.acc  = cyc;
                it.lat  = lat_mode;
                q.push_back(it);
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
            prev_rst   = 0;
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] d, input int s, input int t);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = SW'(s);
        in_tag   = TW'(t);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] d,
                          input int s, input int t, input logic [W-1:0] exp_d, input logic exp_e);
        int p = n_pop;
        int n = 0;
        lat_mode = 1;
        send(op, d, s, t);
        lat_mode = 0;
        while (n_pop == p && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_seen"}, n_pop > p, 1);
        chk({name, "_data"}, last_data, exp_d);
        chk({name, "_err"}, last_err, exp_e);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        run_op("sll1",    3'd0, 32'h8000_0001, 1,  1, 32'h0000_0002, 1'b0);
        run_op("sra31",   3'd2, 32'h8000_0000, 31, 2, 32'hFFFF_FFFF, 1'b0);
        run_op("srl31",   3'd1, 32'h8000_0000, 31, 3, 32'h0000_0001, 1'b0);
        run_op("sra4",    3'd2, 32'h7000_0000, 4,  4, 32'h0700_0000, 1'b0);
        run_op("ror1",    3'd4, 32'h0000_0001, 1,  5, 32'h8000_0000, 1'b0);
        run_op("rol4",    3'd3, 32'h8000_0000, 4,  6, 32'h0000_0008, 1'b0);
        run_op("rol8",    3'd3, 32'h1234_5678, 8,  7, 32'h3456_7812, 1'b0);
        run_op("ror31",   3'd4, 32'h0000_0003, 31, 8, 32'h0000_0006, 1'b0);
        run_op("sra_neg", 3'd2, 32'hF000_1234, 12, 9, 32'hFFFF_0001, 1'b0);
        run_op("rsv6",    3'd6, 32'hDEAD_BEEF, 3, 10, 32'hDEAD_BEEF, 1'b1);
        run_op("rsv7",    3'd7, 32'h0F0F_1234, 0, 11, 32'h0F0F_1234, 1'b1);
        for (int op = 0; op < 5; op++)
            run_op("shamt0", 3'(op), 32'hA5C3_0F96, 0, op, 32'hA5C3_0F96, 1'b0);

        // Backpressure: the pipe holds exactly SW ops while the consumer stalls.
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(3'(i % 5), 32'h9000_0000 + 32'(i * 32'h0101_0101), (i * 7) % 32, i);
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("stall_accept_count", acc_cnt - base, SW);
                chk("stall_in_ready", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Full rate: eight back-to-back accepts in eight cycles.
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            send(3'(i % 8), 32'h1357_9BDF ^ 32'(i << 20), 31 - i * 4, i + 8);
        chk("full_rate_cycles", cyc - c0, 8);
        wait_drain();

        // Mid-stream reset discards in-flight ops; the op offered during reset is ignored.
        for (int i = 0; i < 3; i++)
            send(3'd0, 32'h0000_00F0 + 32'(i), i + 1, i + 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd1;
        in_data  = 32'hCAFE_F00D;
        in_shamt = 5'd2;
        in_tag   = 4'hF;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_ops_after_reset", q.size(), 0);
        run_op("post_reset", 3'd4, 32'h0000_00FF, 4, 12, 32'hF000_000F, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
